regfile_dbg_port: RTL and testbench
===================================

# regfile_dbg_port

Debug command engine on the register file's side port. Accepts READ, WRITE, DUMP and FILL commands over a valid/ready channel and drives `swaddr`/`swdata`/`swena` accordingly. Returns read data from `dff` over a valid/ready response channel. Sits between the board-level console/switch logic and the 32×64 register file, so the CPU core never loses its own ports.

## Interface
Parameters:
- `ADDR_W`, 5: side-port address width
- `DATA_W`, 64: register width
- `NREGS`, 32: registers scanned by DUMP/FILL, ≤ 2^ADDR_W

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: engine accepts; `state==IDLE && !rst`
- `cmd_op` in 2: 00 READ, 01 WRITE, 10 DUMP, 11 FILL
- `cmd_addr` in ADDR_W: target register (READ/WRITE)
- `cmd_data` in DATA_W: write/fill value
- `rsp_valid` out 1: response present
- `rsp_ready` in 1: consumer accepts
- `rsp_addr` out ADDR_W: register the data came from
- `rsp_data` out DATA_W: captured register value
- `rsp_last` out 1: final beat of a command
- `swaddr` out ADDR_W, `swdata` out DATA_W, `swena` out 1: side-port write/read controls, all registered
- `dff` in DATA_W: combinational side-port read data for `swaddr`
- `busy` out 1: `state!=IDLE`

## Operation
- States: IDLE, RD, RSP, WR, FILL.
- Accept = `cmd_valid && cmd_ready`. Fields are sampled only on accept.
- READ: IDLE→RD, `swaddr<=cmd_addr`. In RD: `rsp_data<=dff`, `rsp_addr<=swaddr`, `rsp_valid<=1`, `rsp_last<=1`, go to RSP.
- RSP: hold all `rsp_*` stable until `rsp_valid && rsp_ready`. Then clear `rsp_valid` and go to IDLE.
- WRITE: IDLE→WR with `swaddr<=cmd_addr`, `swdata<=cmd_data`, `swena<=1`. In WR: `swena<=0`, go to IDLE. No response.
- DUMP: IDLE→RD with `swaddr<=0`. Each RD→RSP beat sets `rsp_last = (swaddr==NREGS-1)`. On handshake in RSP:
  - if not last: `swaddr<=swaddr+1`, go to RD
  - if last: go to IDLE
  - Exactly NREGS beats, ascending addresses, no wrap.
- FILL: see Configuration.
- `swena` is never high outside WR/FILL.
- Same-address collision with a core write in the same cycle: the register file resolves it in favour of the side port. The engine does not arbitrate.
- Reset (async, any state):
  - state=IDLE
  - `swena`=0, `swaddr`=0, `swdata`=0
  - `rsp_valid`=0, `rsp_last`=0, `rsp_addr`=0, `rsp_data`=0
  - `busy`=0, `cmd_ready`=0 while `rst` is high
  - Any in-flight command is dropped with no further writes or responses.

## Timing
- Accept at edge T.
- READ: `swaddr` valid after T. `rsp_valid` rises after T+1 (2-cycle latency). `cmd_ready` returns the cycle after the response handshake.
- WRITE: `swena` high for exactly the cycle after T. Register updated at edge T+1. `cmd_ready` high again after T+1.
- DUMP with `rsp_ready` tied high: one beat every 2 cycles, 2·NREGS cycles total. Backpressure stretches RSP only.
- `rsp_valid` never drops without a handshake. `rsp_data` never changes while `rsp_valid` is high.
- FILL: `swena` high cycles T+1..T+NREGS, `swaddr` = 0..NREGS-1. IDLE after T+NREGS.

## Configuration
- `REGDBG_FILL_EN` defined:
  - op 11 = FILL. Writes `cmd_data` to registers 0..NREGS-1, one per cycle.
  - Address counter stops at NREGS-1, then goes to IDLE. No response.
- `REGDBG_FILL_EN` undefined:
  - FILL state is not built.
  - op 11 is accepted and discarded in one cycle: no `swena`, no response, `cmd_ready` high again the next cycle.

## Structure
- Package `regdbg_pkg`: op-code constants (OP_READ, OP_WRITE, OP_DUMP, OP_FILL), state enum, default NREGS/ADDR_W/DATA_W.
- Single module, no sub-module. The address counter and response register are inline. FILL logic sits under the `REGDBG_FILL_EN` guard.

## Test plan
- WRITE addr 5, data 0x0123456789ABCDEF → `swena` high exactly 1 cycle with `swaddr`=5. Then READ 5 → response 2 cycles after accept, `rsp_addr`=5, `rsp_data`=0x0123456789ABCDEF, `rsp_last`=1.
- Preload reg i = i·0x11, DUMP with random `rsp_ready` stalls → 32 beats, addr 0..31 in order, data matches, `rsp_last` only on addr 31, payload stable during stalls.
- FILL 0xDEADBEEF (macro on) → 32 consecutive `swena` cycles, then every register reads 0xDEADBEEF. With macro off → no `swena`, no response, `cmd_ready` back after 1 cycle.
- Assert `rst` mid-DUMP at beat 10 → `rsp_valid`/`swena` low immediately, `cmd_ready` low until release, then a READ 0 completes normally.
- Core write and WRITE to addr 7 in the same cycle → register 7 holds the side-port value. `cmd_valid` held during busy → no second accept until IDLE.

Source files
------------

// File: rtl/regdbg_pkg.sv
// Shared op-codes, FSM state encoding and default geometry for the register-file debug engine.
// The FILL state only exists when REGDBG_FILL_EN is defined.
package regdbg_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned DEF_NREGS  = 32;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;
  localparam logic [1:0] OP_FILL  = 2'b11;

`ifdef REGDBG_FILL_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RSP  = 3'd2,
    ST_WR   = 3'd3,
    ST_FILL = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_RSP  = 3'd2,
    ST_WR   = 3'd3
  } state_e;
`endif

endpackage

// File: rtl/regfile_dbg_port.sv
// Debug command engine driving the register file side port (READ/WRITE/DUMP/FILL).
// Optional feature: define REGDBG_FILL_EN to build the FILL command; otherwise op 11 is discarded.
module regfile_dbg_port
  import regdbg_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREGS  = DEF_NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] swaddr,
  output logic [DATA_W-1:0] swdata,
  output logic              swena,
  input  logic [DATA_W-1:0] dff,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  state_e            state_q, state_d;
  logic              dump_q, dump_d;
  logic [ADDR_W-1:0] swaddr_d;
  logic [DATA_W-1:0] swdata_d;
  logic              swena_d;
  logic              rsp_valid_d;
  logic              rsp_last_d;
  logic [ADDR_W-1:0] rsp_addr_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              accept;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign busy      = (state_q != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // Next-state and next-register values; swena defaults low so it only pulses in WR/FILL.
  always_comb begin
    state_d     = state_q;
    dump_d      = dump_q;
    swaddr_d    = swaddr;
    swdata_d    = swdata;
    swena_d     = 1'b0;
    rsp_valid_d = rsp_valid;
    rsp_last_d  = rsp_last;
    rsp_addr_d  = rsp_addr;
    rsp_data_d  = rsp_data;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_READ: begin
              swaddr_d = cmd_addr;
              dump_d   = 1'b0;
              state_d  = ST_RD;
            end
            OP_WRITE: begin
              swaddr_d = cmd_addr;
              swdata_d = cmd_data;
              swena_d  = 1'b1;
              state_d  = ST_WR;
            end
            OP_DUMP: begin
              swaddr_d = '0;
              dump_d   = 1'b1;
              state_d  = ST_RD;
            end
            default: begin
`ifdef REGDBG_FILL_EN
              swaddr_d = '0;
              swdata_d = cmd_data;
              swena_d  = 1'b1;
              state_d  = ST_FILL;
`else
              state_d  = ST_IDLE;
`endif
            end
          endcase
        end
      end

      ST_RD: begin
        rsp_data_d  = dff;
        rsp_addr_d  = swaddr;
        rsp_valid_d = 1'b1;
        rsp_last_d  = dump_q ? (swaddr == LAST_ADDR) : 1'b1;
        state_d     = ST_RSP;
      end

      // Response payload is frozen here until the consumer takes it.
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (dump_q && !rsp_last) begin
            swaddr_d = swaddr + ADDR_W'(1);
            state_d  = ST_RD;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end

      ST_WR: begin
        state_d = ST_IDLE;
      end

`ifdef REGDBG_FILL_EN
      ST_FILL: begin
        if (swaddr == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          swaddr_d = swaddr + ADDR_W'(1);
          swena_d  = 1'b1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any in-flight command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dump_q    <= 1'b0;
      swaddr    <= '0;
      swdata    <= '0;
      swena     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
    end else begin
      state_q   <= state_d;
      dump_q    <= dump_d;
      swaddr    <= swaddr_d;
      swdata    <= swdata_d;
      swena     <= swena_d;
      rsp_valid <= rsp_valid_d;
      rsp_last  <= rsp_last_d;
      rsp_addr  <= rsp_addr_d;
      rsp_data  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Self-checking bench for regfile_dbg_port with a behavioural 32x64 register file and a response scoreboard.
module tb_regfile_dbg_port;
  import regdbg_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 64;
  localparam int unsigned NR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic [AW-1:0] swaddr;
  logic [DW-1:0] swdata;
  logic          swena;
  logic [DW-1:0] dff;
  logic          busy;

  logic          core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_data = '0;

  logic [DW-1:0] rf [NR];
  logic [DW-1:0] exp_regs [NR];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } rsp_t;
  rsp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Register file: side port wins a same-address collision with the core port.
  always @(posedge clk) begin
    if (core_we) rf[core_addr] <= core_data;
    if (swena)   rf[swaddr]    <= swdata;
  end
  assign dff = rf[swaddr];

  regfile_dbg_port #(.ADDR_W(AW), .DATA_W(DW), .NREGS(NR)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_last(rsp_last),
    .swaddr(swaddr), .swdata(swdata), .swena(swena),
    .dff(dff), .busy(busy)
  );

  // Drive one command; returns at the falling edge after the accepting edge with cmd_valid dropped.
  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, rsp_valid, rsp_last, swena, swaddr, swdata, rsp_addr, rsp_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b rsp_valid=%b rsp_last=%b swena=%b swaddr=%0d swdata=%h rsp_addr=%0d rsp_data=%h required all 0",
               busy, rsp_valid, rsp_last, swena, swaddr, swdata, rsp_addr, rsp_data);
    end
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_idle: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] v;
    rsp_t e;
    v = 64'h0123456789ABCDEF;
    send_cmd(OP_WRITE, AW'(5), v);
    exp_regs[5] = v;
    vectors++;
    if (swena !== 1'b1 || swaddr !== AW'(5) || swdata !== v || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL write_strobe: swena=%b swaddr=%0d swdata=%h busy=%b cmd_ready=%b required 1/5/%h/1/0",
               swena, swaddr, swdata, busy, cmd_ready, v);
    end
    @(negedge clk);
    vectors++;
    if (swena !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL write_one_cycle: swena=%b cmd_ready=%b required 0/1", swena, cmd_ready);
    end
    sb.push_back('{addr: AW'(5), data: v, last: 1'b1});
    send_cmd(OP_READ, AW'(5), '0);
    vectors++;
    if (rsp_valid !== 1'b0 || swaddr !== AW'(5)) begin
      miscompares++; $display("FAIL read_addr_phase: rsp_valid=%b swaddr=%0d required 0/5", rsp_valid, swaddr);
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++; $display("FAIL read_latency: rsp_valid=%b required 1 two cycles after accept", rsp_valid);
    end
    rsp_ready = 1'b1;
    if (rsp_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if ({rsp_addr, rsp_data, rsp_last} !== {e.addr, e.data, e.last}) begin
        miscompares++;
        $display("FAIL read_rsp: addr=%0d data=%h last=%b required %0d/%h/%b", rsp_addr, rsp_data, rsp_last, e.addr, e.data, e.last);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL read_done: rsp_valid=%b cmd_ready=%b pending=%0d required 0/1/0", rsp_valid, cmd_ready, sb.size());
    end
  endtask

  task automatic test_dump_stalls();
    int beats;
    logic stalled;
    logic [AW+DW:0] held;
    rsp_t e;
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      core_we = 1'b1; core_addr = AW'(i); core_data = DW'(i * 17);
      exp_regs[i] = DW'(i * 17);
    end
    @(negedge clk);
    core_we = 1'b0;
    for (int i = 0; i < NR; i++) sb.push_back('{addr: AW'(i), data: exp_regs[i], last: (i == NR - 1)});
    send_cmd(OP_DUMP, '0, '0);
    beats = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 4000 && beats < NR; c++) begin
      if (stalled) begin
        vectors++;
        if (rsp_valid !== 1'b1 || {rsp_addr, rsp_data, rsp_last} !== held) begin
          miscompares++;
          $display("FAIL dump_stall_stable: valid=%b payload=%h required 1/%h", rsp_valid, {rsp_addr, rsp_data, rsp_last}, held);
        end
      end
      if (swena !== 1'b0) begin
        vectors++; miscompares++; $display("FAIL dump_swena: swena=%b required 0", swena);
      end
      if (rsp_valid === 1'b1) begin
        rsp_ready = ($urandom_range(0, 2) != 0);
        if (rsp_ready) begin
          stalled = 1'b0;
          beats++;
          vectors++;
          if (sb.size() == 0) begin
            miscompares++; $display("FAIL dump_extra_beat: addr=%0d required none", rsp_addr);
          end else begin
            e = sb.pop_front();
            if ({rsp_addr, rsp_data, rsp_last} !== {e.addr, e.data, e.last}) begin
              miscompares++;
              $display("FAIL dump_beat: addr=%0d data=%h last=%b required %0d/%h/%b", rsp_addr, rsp_data, rsp_last, e.addr, e.data, e.last);
            end
          end
        end else begin
          stalled = 1'b1;
          held = {rsp_addr, rsp_data, rsp_last};
        end
      end else begin
        stalled = 1'b0;
        rsp_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    vectors++;
    if (beats != NR || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL dump_end: beats=%0d busy=%b rsp_valid=%b required %0d/0/0", beats, busy, rsp_valid, NR);
    end
    sb.delete();
  endtask

  task automatic test_dump_fullrate();
    int cycles;
    rsp_t e;
    for (int i = 0; i < NR; i++) sb.push_back('{addr: AW'(i), data: exp_regs[i], last: (i == NR - 1)});
    rsp_ready = 1'b1;
    send_cmd(OP_DUMP, '0, '0);
    cycles = 0;
    while (busy === 1'b1 && cycles < 500) begin
      if (rsp_valid === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL fullrate_extra_beat: addr=%0d required none", rsp_addr);
        end else begin
          e = sb.pop_front();
          if ({rsp_addr, rsp_data, rsp_last} !== {e.addr, e.data, e.last}) begin
            miscompares++;
            $display("FAIL fullrate_beat: addr=%0d data=%h last=%b required %0d/%h/%b", rsp_addr, rsp_data, rsp_last, e.addr, e.data, e.last);
          end
        end
      end
      cycles++;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    vectors++;
    if (cycles != 2 * NR || sb.size() != 0) begin
      miscompares++; $display("FAIL fullrate_cycles: busy_cycles=%0d pending=%0d required %0d/0", cycles, sb.size(), 2 * NR);
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    rsp_t e;
    logic got;
    rsp_ready = 1'b0;
    sb.push_back('{addr: AW'(3), data: exp_regs[3], last: 1'b1});
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = AW'(3); cmd_data = '0;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) cmd_addr = AW'(9);
      vectors++;
      if (cmd_ready !== 1'b0 || swaddr !== AW'(3)) begin
        miscompares++; $display("FAIL held_no_accept: cmd_ready=%b swaddr=%0d required 0/3", cmd_ready, swaddr);
      end
    end
    rsp_ready = 1'b1;
    e = sb.pop_front();
    vectors++;
    if (rsp_valid !== 1'b1 || {rsp_addr, rsp_data, rsp_last} !== {e.addr, e.data, e.last}) begin
      miscompares++;
      $display("FAIL held_first_rsp: valid=%b addr=%0d data=%h last=%b required 1/%0d/%h/%b", rsp_valid, rsp_addr, rsp_data, rsp_last, e.addr, e.data, e.last);
    end
    sb.push_back('{addr: AW'(9), data: exp_regs[9], last: 1'b1});
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL held_ready_after_rsp: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || swaddr !== AW'(9)) begin
      miscompares++; $display("FAIL held_second_accept: busy=%b swaddr=%0d required 1/9", busy, swaddr);
    end
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        rsp_ready = 1'b1;
        e = sb.pop_front();
        got = 1'b1;
        vectors++;
        if ({rsp_addr, rsp_data, rsp_last} !== {e.addr, e.data, e.last}) begin
          miscompares++;
          $display("FAIL held_second_rsp: addr=%0d data=%h last=%b required %0d/%h/%b", rsp_addr, rsp_data, rsp_last, e.addr, e.data, e.last);
        end
        break;
      end
    end
    if (!got) begin
      vectors++; miscompares++; $display("FAIL held_second_timeout: rsp_valid=%b required 1", rsp_valid);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    sb.delete();
  endtask

  task automatic test_collision();
    rsp_t e;
    logic got;
    send_cmd(OP_WRITE, AW'(7), 64'hA5A5_0000_1111_7777);
    core_we = 1'b1; core_addr = AW'(7); core_data = 64'h0BAD_0BAD_0BAD_0BAD;
    exp_regs[7] = 64'hA5A5_0000_1111_7777;
    @(negedge clk);
    core_we = 1'b0;
    sb.push_back('{addr: AW'(7), data: exp_regs[7], last: 1'b1});
    send_cmd(OP_READ, AW'(7), '0);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        rsp_ready = 1'b1;
        e = sb.pop_front();
        got = 1'b1;
        vectors++;
        if ({rsp_addr, rsp_data, rsp_last} !== {e.addr, e.data, e.last}) begin
          miscompares++;
          $display("FAIL collision_rsp: addr=%0d data=%h last=%b required %0d/%h/%b", rsp_addr, rsp_data, rsp_last, e.addr, e.data, e.last);
        end
        break;
      end
    end
    if (!got) begin
      vectors++; miscompares++; $display("FAIL collision_timeout: rsp_valid=%b required 1", rsp_valid);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    sb.delete();
  endtask

  task automatic test_fill();
    logic [DW-1:0] v;
    v = 64'h0000_0000_DEAD_BEEF;
`ifdef REGDBG_FILL_EN
    begin
      int cycles;
      rsp_t e;
      send_cmd(OP_FILL, '0, v);
      for (int k = 0; k < NR; k++) begin
        vectors++;
        if (swena !== 1'b1 || swaddr !== AW'(k) || swdata !== v) begin
          miscompares++;
          $display("FAIL fill_write: cycle=%0d swena=%b swaddr=%0d swdata=%h required 1/%0d/%h", k, swena, swaddr, swdata, k, v);
        end
        @(negedge clk);
      end
      vectors++;
      if (swena !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_end: swena=%b busy=%b cmd_ready=%b rsp_valid=%b required 0/0/1/0", swena, busy, cmd_ready, rsp_valid);
      end
      for (int i = 0; i < NR; i++) begin
        exp_regs[i] = v;
        sb.push_back('{addr: AW'(i), data: v, last: (i == NR - 1)});
      end
      rsp_ready = 1'b1;
      send_cmd(OP_DUMP, '0, '0);
      cycles = 0;
      while (busy === 1'b1 && cycles < 500) begin
        if (rsp_valid === 1'b1 && sb.size() > 0) begin
          e = sb.pop_front();
          vectors++;
          if ({rsp_addr, rsp_data, rsp_last} !== {e.addr, e.data, e.last}) begin
            miscompares++;
            $display("FAIL fill_readback: addr=%0d data=%h last=%b required %0d/%h/%b", rsp_addr, rsp_data, rsp_last, e.addr, e.data, e.last);
          end
        end
        cycles++;
        @(negedge clk);
      end
      rsp_ready = 1'b0;
      vectors++;
      if (sb.size() != 0) begin
        miscompares++; $display("FAIL fill_readback_count: pending=%0d required 0", sb.size());
      end
      sb.delete();
    end
`else
    send_cmd(OP_FILL, AW'(3), v);
    vectors++;
    if (swena !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_discard: swena=%b rsp_valid=%b cmd_ready=%b required 0/0/1", swena, rsp_valid, cmd_ready);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (swena !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_quiet: swena=%b rsp_valid=%b busy=%b required 0/0/0", swena, rsp_valid, busy);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_dump();
    int beats;
    rsp_t e;
    logic got;
    for (int i = 0; i < NR; i++) sb.push_back('{addr: AW'(i), data: exp_regs[i], last: (i == NR - 1)});
    rsp_ready = 1'b1;
    send_cmd(OP_DUMP, '0, '0);
    beats = 0;
    for (int c = 0; c < 200 && beats < 10; c++) begin
      if (rsp_valid === 1'b1) begin
        e = sb.pop_front();
        beats++;
        vectors++;
        if ({rsp_addr, rsp_data, rsp_last} !== {e.addr, e.data, e.last}) begin
          miscompares++;
          $display("FAIL pre_reset_beat: addr=%0d data=%h last=%b required %0d/%h/%b", rsp_addr, rsp_data, rsp_last, e.addr, e.data, e.last);
        end
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    for (int c = 0; c < 4 && rsp_valid !== 1'b1; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if ({rsp_valid, swena, cmd_ready, busy, rsp_last, rsp_addr, rsp_data, swaddr} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_dump: rsp_valid=%b swena=%b cmd_ready=%b busy=%b rsp_last=%b rsp_addr=%0d rsp_data=%h swaddr=%0d required all 0",
               rsp_valid, swena, cmd_ready, busy, rsp_last, rsp_addr, rsp_data, swaddr);
    end
    sb.delete();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
        miscompares++; $display("FAIL reset_hold: cmd_ready=%b rsp_valid=%b required 0/0", cmd_ready, rsp_valid);
      end
    end
    rst = 1'b0;
    sb.push_back('{addr: AW'(0), data: exp_regs[0], last: 1'b1});
    send_cmd(OP_READ, AW'(0), '0);
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        rsp_ready = 1'b1;
        e = sb.pop_front();
        got = 1'b1;
        vectors++;
        if ({rsp_addr, rsp_data, rsp_last} !== {e.addr, e.data, e.last}) begin
          miscompares++;
          $display("FAIL post_reset_read: addr=%0d data=%h last=%b required %0d/%h/%b", rsp_addr, rsp_data, rsp_last, e.addr, e.data, e.last);
        end
        break;
      end
    end
    if (!got) begin
      vectors++; miscompares++; $display("FAIL post_reset_timeout: rsp_valid=%b required 1", rsp_valid);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_idle: busy=%b rsp_valid=%b required 0/0", busy, rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_dump_stalls();
    test_dump_fullrate();
    test_back_to_back();
    test_collision();
    test_fill();
    test_reset_mid_dump();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
